// File: rtl/pipelined_control_unit.sv
// Pipelined RV32I control path: decode in D, registered control words through E, M and W.
// Optional build macro PCU_BRANCH_EXT_EN enables bne/blt/bge resolution using NegE.
module pipelined_control_unit #(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [6:0]            OP,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic                  FlushE,
    input  logic                  ZeroE,
    input  logic                  NegE,
    output logic [1:0]            ImmSrcD,
    output logic                  IllegalD,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  ALUSrcE,
    output logic                  ResultSrcE0,
    output logic                  PCSrcE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Decode-stage control word
    logic                  reg_write_d;
    logic [1:0]            result_src_d;
    logic                  mem_write_d;
    logic                  jump_d;
    logic                  branch_d;
    logic [3:0]            alu_code_d;
    logic [ALU_CTRL_W-1:0] alu_ctrl_d;
    logic                  alu_src_d;
    logic                  ext_op_d;
    logic                  branch_ok_d;

    // Execute-stage registers
    logic                  reg_write_e;
    logic [1:0]            result_src_e;
    logic                  mem_write_e;
    logic                  jump_e;
    logic                  branch_e;
    logic [ALU_CTRL_W-1:0] alu_ctrl_e;
    logic                  alu_src_e;
    logic [2:0]            funct3_e;
    logic                  taken_e;

    // Memory and Writeback registers
    logic                  reg_write_m;
    logic [1:0]            result_src_m;
    logic                  mem_write_m;
    logic                  reg_write_w;
    logic [1:0]            result_src_w;

    logic                  unused_alu_msb;

`ifdef PCU_BRANCH_EXT_EN
    assign branch_ok_d = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                         (funct3 == 3'b100) || (funct3 == 3'b101);
`else
    assign branch_ok_d = (funct3 == 3'b000);
`endif

    always_comb begin
        reg_write_d  = 1'b0;
        result_src_d = 2'b00;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_code_d   = ALU_ADD;
        alu_src_d    = 1'b0;
        ImmSrcD      = 2'b00;
        IllegalD     = 1'b0;
        ext_op_d     = 1'b0;
        case (OP)
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                ImmSrcD     = 2'b01;
            end
            OP_R, OP_I: begin
                reg_write_d = 1'b1;
                alu_src_d   = (OP == OP_I);
                // funct7 only distinguishes sub (R-type) and sra/srai
                case (funct3)
                    3'b000: alu_code_d = (OP[5] && funct7) ? ALU_SUB : ALU_ADD;
                    3'b001: begin alu_code_d = ALU_SLL;  ext_op_d = 1'b1; end
                    3'b010: alu_code_d = ALU_SLT;
                    3'b011: begin alu_code_d = ALU_SLTU; ext_op_d = 1'b1; end
                    3'b100: begin alu_code_d = ALU_XOR;  ext_op_d = 1'b1; end
                    3'b101: begin
                        alu_code_d = funct7 ? ALU_SRA : ALU_SRL;
                        ext_op_d   = 1'b1;
                    end
                    3'b110: alu_code_d = ALU_OR;
                    default: alu_code_d = ALU_AND;
                endcase
                // Legacy ALU cannot execute these: suppress all architectural side effects
                if (ALU_CTRL_W < 4 && ext_op_d) begin
                    alu_code_d  = ALU_ADD;
                    reg_write_d = 1'b0;
                    IllegalD    = 1'b1;
                end
            end
            OP_BR: begin
                branch_d   = 1'b1;
                alu_code_d = ALU_SUB;
                ImmSrcD    = 2'b10;
                IllegalD   = !branch_ok_d;
            end
            OP_JAL: begin
                jump_d       = 1'b1;
                reg_write_d  = 1'b1;
                result_src_d = 2'b10;
                ImmSrcD      = 2'b11;
            end
            default: IllegalD = 1'b1;
        endcase
    end

    assign alu_ctrl_d     = alu_code_d[ALU_CTRL_W-1:0];
    assign unused_alu_msb = alu_code_d[3];

    always_ff @(posedge CLK) begin
        if (RST || FlushE) begin
            reg_write_e  <= 1'b0;
            result_src_e <= 2'b00;
            mem_write_e  <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            alu_ctrl_e   <= '0;
            alu_src_e    <= 1'b0;
            funct3_e     <= 3'b000;
        end else begin
            reg_write_e  <= reg_write_d;
            result_src_e <= result_src_d;
            mem_write_e  <= mem_write_d;
            jump_e       <= jump_d;
            branch_e     <= branch_d;
            alu_ctrl_e   <= alu_ctrl_d;
            alu_src_e    <= alu_src_d;
            funct3_e     <= funct3;
        end
    end

`ifdef PCU_BRANCH_EXT_EN
    always_comb begin
        case (funct3_e)
            3'b000:  taken_e = ZeroE;
            3'b001:  taken_e = !ZeroE;
            3'b100:  taken_e = NegE;
            3'b101:  taken_e = !NegE;
            default: taken_e = 1'b0;
        endcase
    end
`else
    logic [3:0] unused_branch_ext;
    assign unused_branch_ext = {NegE, funct3_e};
    assign taken_e = ZeroE;
`endif

    assign PCSrcE = jump_e | (branch_e & taken_e);

    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            mem_write_m  <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
        end else begin
            reg_write_m  <= reg_write_e;
            result_src_m <= result_src_e;
            mem_write_m  <= mem_write_e;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    assign ALUControlE = alu_ctrl_e;
    assign ALUSrcE     = alu_src_e;
    assign ResultSrcE0 = result_src_e[0];
    assign RegWriteM   = reg_write_m;
    assign MemWriteM   = mem_write_m;
    assign ResultSrcM  = result_src_m;
    assign RegWriteW   = reg_write_w;
    assign ResultSrcW  = result_src_w;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: legacy (3-bit) and extended (4-bit) ALU builds driven in parallel,
// checked every cycle against an instruction-level model plus directed literal expectations.
module tb_pipelined_control_unit;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;
`ifdef PCU_BRANCH_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST, funct7, FlushE, ZeroE, NegE;
    logic [6:0] OP;
    logic [2:0] funct3;

    logic [1:0] imm3, imm4, rsm3, rsm4, rsw3, rsw4;
    logic       ill3, ill4, alusrc3, alusrc4, rse0_3, rse0_4, pcs3, pcs4;
    logic       rwm3, rwm4, mwm3, mwm4, rww3, rww4;
    logic [2:0] alu3;
    logic [3:0] alu4;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    pipelined_control_unit #(.ALU_CTRL_W(3)) u3 (
        .CLK(CLK), .RST(RST), .OP(OP), .funct3(funct3), .funct7(funct7),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE),
        .ImmSrcD(imm3), .IllegalD(ill3), .ALUControlE(alu3), .ALUSrcE(alusrc3),
        .ResultSrcE0(rse0_3), .PCSrcE(pcs3), .RegWriteM(rwm3), .MemWriteM(mwm3),
        .ResultSrcM(rsm3), .RegWriteW(rww3), .ResultSrcW(rsw3));

    pipelined_control_unit #(.ALU_CTRL_W(4)) u4 (
        .CLK(CLK), .RST(RST), .OP(OP), .funct3(funct3), .funct7(funct7),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE),
        .ImmSrcD(imm4), .IllegalD(ill4), .ALUControlE(alu4), .ALUSrcE(alusrc4),
        .ResultSrcE0(rse0_4), .PCSrcE(pcs4), .RegWriteM(rwm4), .MemWriteM(mwm4),
        .ResultSrcM(rsm4), .RegWriteW(rww4), .ResultSrcW(rsw4));

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       jump;
        logic       branch;
        logic [3:0] alu;
        logic       alusrc;
        logic [2:0] f3;
        logic [1:0] imm;
        logic       ill;
    } ctl_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Instruction-level meaning: which mnemonic is this, and what does it need from the pipeline
    function automatic ctl_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int w);
        ctl_t c;
        int   code;
        c    = '0;
        c.f3 = f3;
        if (op == LW) begin
            c.rw = 1; c.alusrc = 1; c.rs = 2'd1;
        end else if (op == SW) begin
            c.mw = 1; c.alusrc = 1; c.imm = 2'd1;
        end else if (op == RT || op == IT) begin
            case (f3)
                3'd0: code = (op == RT && f7) ? 1 : 0;
                3'd1: code = 6;
                3'd2: code = 5;
                3'd3: code = 9;
                3'd4: code = 4;
                3'd5: code = f7 ? 8 : 7;
                3'd6: code = 3;
                default: code = 2;
            endcase
            c.alusrc = (op == IT);
            if (w == 3 && (code == 4 || code >= 6)) begin
                c.ill = 1;
            end else begin
                c.alu = code[3:0];
                c.rw  = 1;
            end
        end else if (op == BR) begin
            c.branch = 1; c.imm = 2'd2; c.alu = 4'd1;
            c.ill = EXT ? !(f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5) : (f3 != 0);
        end else if (op == JAL) begin
            c.jump = 1; c.rw = 1; c.rs = 2'd2; c.imm = 2'd3;
        end else begin
            c.ill = 1;
        end
        return c;
    endfunction

    function automatic logic pc_sel(input ctl_t e, input logic z, input logic n);
        logic t;
        if (!EXT)         t = z;
        else if (e.f3 == 0) t = z;
        else if (e.f3 == 1) t = !z;
        else if (e.f3 == 4) t = n;
        else if (e.f3 == 5) t = !n;
        else              t = 0;
        return e.jump | (e.branch & t);
    endfunction

    ctl_t e3, m3, w3, e4, m4, w4, d3, d4;
    bit   mvalid = 0;

    always @(posedge CLK) begin
        if (RST) begin
            e3 = '0; m3 = '0; w3 = '0; e4 = '0; m4 = '0; w4 = '0;
            mvalid = 1;
        end else begin
            w3 = m3; m3 = e3; e3 = FlushE ? '0 : model(OP, funct3, funct7, 3);
            w4 = m4; m4 = e4; e4 = FlushE ? '0 : model(OP, funct3, funct7, 4);
        end
    end

    task automatic check_set(input string t, input logic [1:0] imm, input logic ill,
                             input logic [3:0] alu, input logic alusrc, input logic rse0,
                             input logic pcs, input logic rwm, input logic mwm,
                             input logic [1:0] rsm, input logic rww, input logic [1:0] rsw,
                             input ctl_t d, input ctl_t e, input ctl_t m, input ctl_t w);
        chk({t, " ImmSrcD"},     imm,    d.imm);
        chk({t, " IllegalD"},    ill,    d.ill);
        chk({t, " ALUControlE"}, alu,    e.alu);
        chk({t, " ALUSrcE"},     alusrc, e.alusrc);
        chk({t, " ResultSrcE0"}, rse0,   e.rs[0]);
        chk({t, " PCSrcE"},      pcs,    pc_sel(e, ZeroE, NegE));
        chk({t, " RegWriteM"},   rwm,    m.rw);
        chk({t, " MemWriteM"},   mwm,    m.mw);
        chk({t, " ResultSrcM"},  rsm,    m.rs);
        chk({t, " RegWriteW"},   rww,    w.rw);
        chk({t, " ResultSrcW"},  rsw,    w.rs);
    endtask

    always @(negedge CLK) begin
        if (mvalid) begin
            d3 = model(OP, funct3, funct7, 3);
            d4 = model(OP, funct3, funct7, 4);
            check_set("w3", imm3, ill3, {1'b0, alu3}, alusrc3, rse0_3, pcs3, rwm3, mwm3, rsm3,
                      rww3, rsw3, d3, e3, m3, w3);
            check_set("w4", imm4, ill4, alu4, alusrc4, rse0_4, pcs4, rwm4, mwm4, rsm4,
                      rww4, rsw4, d4, e4, m4, w4);
        end
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic n, input logic fl, input logic rst);
        OP = op; funct3 = f3; funct7 = f7; ZeroE = z; NegE = n; FlushE = fl; RST = rst;
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick; tick;
        chk("rst RegWriteM", rwm3, 0);
        chk("rst PCSrcE", pcs3, 0);
        chk("rst ALUControlE", alu4, 0);
        chk("rst ResultSrcW", rsw4, 0);

        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("add ImmSrcD", imm3, 0);
        tick;
        drive(LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("release RegWriteM", rwm3, 1);
        drive(SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("sw ImmSrcD", imm3, 1);
        tick;
        chk("release RegWriteW", rww3, 1);
        chk("sw ALUSrcE", alusrc3, 1);
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("sw MemWriteM", mwm3, 1);
        chk("lw ResultSrcW", rsw3, 1);
        chk("add ALUControlE", alu3, 0);
        drive(RT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("sub ALUControlE", alu3, 1);

        drive(BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("beq ImmSrcD", imm3, 2);
        tick;
        drive(IT, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("beq taken PCSrcE", pcs3, 1);
        tick;
        drive(BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        drive(IT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("beq not taken PCSrcE", pcs3, 0);
        tick;
        drive(JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("jal ImmSrcD", imm3, 3);
        tick;
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("jal PCSrcE", pcs4, 1);
        tick;
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("jal ResultSrcW", rsw3, 2);

        drive(LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick;
        chk("flush ResultSrcE0", rse0_3, 0);
        chk("flush ALUSrcE", alusrc3, 0);
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("flush RegWriteM", rwm3, 0);
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("flush RegWriteW", rww3, 0);

        drive(RT, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("sra IllegalD w3", ill3, 1);
        chk("sra IllegalD w4", ill4, 0);
        tick;
        chk("sra ALUControlE w4", alu4, 8);
        chk("sra ALUControlE w3", alu3, 0);
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("sra RegWriteM w3", rwm3, 0);
        chk("sra RegWriteM w4", rwm4, 1);

        drive(BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("bne IllegalD", ill3, EXT ? 0 : 1);
        tick;
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("bne PCSrcE", pcs3, EXT ? 1 : 0);
        tick;
        drive(BR, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        drive(RT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("blt PCSrcE", pcs4, EXT ? 1 : 0);
        tick;

        drive(BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        drive(RT, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        chk("branch+flush PCSrcE", pcs3, 1);
        tick;
        chk("bubble PCSrcE", pcs3, 0);

        drive(BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("bad IllegalD", ill4, 1);
        chk("bad ImmSrcD", imm4, 0);
        tick;
        chk("bad RegWrite path", alusrc4, 0);

        drive(JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick;
        chk("rst+flush PCSrcE", pcs3, 0);

        drive(IT, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        chk("srai ALUControlE w4", alu4, 8);

        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 8; f++) begin
                for (int s = 0; s < 2; s++) begin
                    drive((k == 0) ? IT : RT, 3'(f), 1'(s), 1'(f & 1), 1'(s), 1'b0, 1'b0);
                    tick;
                end
            end
        end
        for (int f = 0; f < 8; f++) begin
            drive(BR, 3'(f), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
            drive(SW, 3'd2, 1'b0, 1'(f >> 1), 1'(f), 1'b0, 1'b0); tick;
        end
        for (int j = 0; j < 3; j++) begin
            drive(RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
